// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and op-classification helpers for the HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MADD  = 4'd4,
    MADDU = 4'd5,
    MSUB  = 4'd6,
    MSUBU = 4'd7,
    MTHI  = 4'd8,
    MTLO  = 4'd9
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic is_acc_op(input muldiv_op_t o);
    return (o == MADD) || (o == MADDU) || (o == MSUB) || (o == MSUBU);
  endfunction

  function automatic logic is_mul_op(input muldiv_op_t o);
    return (o == MULT) || (o == MULTU) || is_acc_op(o);
  endfunction

  function automatic logic is_div_op(input muldiv_op_t o);
    return (o == DIV) || (o == DIVU);
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t o);
    return (o == MULT) || (o == DIV) || (o == MADD) || (o == MSUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_step_unit
// Description : One combinational restoring shift-subtract divide step.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step_unit (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_dvs,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_shift;
  logic        w_ge;

  assign w_shift = {i_rem, i_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, i_dvs});
  // When the subtract is taken the result is below the divisor, so 32 bits hold it.
  assign o_rem   = w_ge ? (w_shift[31:0] - i_dvs) : w_shift[31:0];
  assign o_quo   = {i_quo[30:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : HI/LO unit controller: pipelined multiply, iterative divide,
//               MTHI/MTLO, stall generation. MULDIV_ACCUMULATE_EN enables
//               MADD/MADDU/MSUB/MSUBU; otherwise those ops raise ill.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_ITER    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        read_req,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        ill,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = 6;

  state_t             r_state;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  muldiv_op_t         r_op;
  logic [31:0]        r_a, r_b, r_hi, r_lo;
  logic [31:0]        r_rem, r_quo, r_dvs;
  logic               r_neg_q, r_neg_r;

  logic               w_ill, w_accept, w_mul_last;
  logic               w_rs_neg, w_rt_neg;
  logic [31:0]        w_rs_mag, w_rt_mag, w_rem_nx, w_quo_nx;
  logic [63:0]        w_ext_a, w_ext_b, w_prod, w_prod_q, w_mul_res;

`ifdef MULDIV_ACCUMULATE_EN
  assign w_ill = 1'b0;
`else
  assign w_ill = start & is_acc_op(op);
`endif

  assign w_accept   = start & ~r_busy & ~cancel & ~w_ill;
  assign w_mul_last = (r_state == ST_MUL) && (r_cnt == CNT_W'(1));

  assign busy  = r_busy;
  assign ill   = w_ill;
  assign stall = r_busy & ((start & ~w_ill) | read_req);
  assign done  = (w_mul_last | (r_state == ST_FIX)) & ~cancel;
  assign hi    = r_hi;
  assign lo    = r_lo;

  assign w_ext_a = is_signed_op(r_op) ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_ext_b = is_signed_op(r_op) ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Operands stay stable through MUL, so the chain just models multiplier depth.
  generate
    if (MUL_LATENCY > 1) begin : g_mul_pipe
      logic [MUL_LATENCY-2:0][63:0] r_pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= w_prod;
          for (int i = 1; i < MUL_LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_prod_q = r_pipe[MUL_LATENCY-2];
    end else begin : g_mul_comb
      assign w_prod_q = w_prod;
    end
  endgenerate

`ifdef MULDIV_ACCUMULATE_EN
  always_comb begin
    w_mul_res = w_prod_q;
    if (r_op == MADD || r_op == MADDU) w_mul_res = {r_hi, r_lo} + w_prod_q;
    else if (r_op == MSUB || r_op == MSUBU) w_mul_res = {r_hi, r_lo} - w_prod_q;
  end
`else
  assign w_mul_res = w_prod_q;
`endif

  assign w_rs_neg = is_signed_op(op) & rs_val[31];
  assign w_rt_neg = is_signed_op(op) & rt_val[31];
  assign w_rs_mag = w_rs_neg ? (32'd0 - rs_val) : rs_val;
  assign w_rt_mag = w_rt_neg ? (32'd0 - rt_val) : rt_val;

  div_step_unit u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_op    <= MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (cancel && r_busy) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (is_mul_op(op)) begin
              r_op    <= op;
              r_a     <= rs_val;
              r_b     <= rt_val;
              r_cnt   <= CNT_W'(MUL_LATENCY);
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
            end else if (is_div_op(op)) begin
              r_op    <= op;
              r_quo   <= w_rs_mag;
              r_dvs   <= w_rt_mag;
              r_rem   <= '0;
              r_neg_q <= w_rs_neg ^ w_rt_neg;
              r_neg_r <= w_rs_neg;
              r_cnt   <= CNT_W'(DIV_ITER);
              r_state <= ST_DIV;
              r_busy  <= 1'b1;
            end else if (op == MTHI) begin
              r_hi <= rs_val;
            end else if (op == MTLO) begin
              r_lo <= rs_val;
            end
          end
        end
        ST_MUL: begin
          if (r_cnt == CNT_W'(1)) begin
            {r_hi, r_lo} <= w_mul_res;
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
          end
          r_cnt <= r_cnt - 1'b1;
        end
        ST_DIV: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_lo    <= r_neg_q ? (32'd0 - r_quo) : r_quo;
          r_hi    <= r_neg_r ? (32'd0 - r_rem) : r_rem;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int LAT  = 3;
  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        rst_n, start, read_req, cancel;
  muldiv_op_t  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, done, ill;
  logic [31:0] hi, lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  muldiv_sequencer #(.MUL_LATENCY(LAT), .DIV_ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .read_req(read_req), .cancel(cancel), .busy(busy),
    .stall(stall), .done(done), .ill(ill), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_acc(input muldiv_op_t o);
    return o inside {MADD, MADDU, MSUB, MSUBU};
  endfunction

  // Architectural result {hi,lo} computed with plain wide arithmetic.
  function automatic logic [63:0] ref_result(input muldiv_op_t o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hl);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     ps, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ps = sa * sb;
    pu = ua * ub;
    case (o)
      MULT:  return ps;
      MULTU: return pu;
      MADD:  return hl + ps;
      MADDU: return hl + pu;
      MSUB:  return hl - ps;
      MSUBU: return hl - pu;
      DIV: begin
        if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MTHI:  return {a, hl[31:0]};
      MTLO:  return {hl[63:32], a};
      default: return hl;
    endcase
  endfunction

  task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [63:0] exp;
    int          n, lat;
    logic        all_busy;
    exp    = ref_result(o, a, b, {m_hi, m_lo});
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    #1;
`ifndef MULDIV_ACCUMULATE_EN
    if (is_acc(o)) begin
      check({tag, "_ill"}, ill, 1);
      tick();
      start = 1'b0;
      check({tag, "_ill_busy"}, busy, 0);
      check({tag, "_ill_hilo"}, {hi, lo}, {m_hi, m_lo});
      return;
    end
`endif
    tick();
    start = 1'b0;
    if (o == MTHI || o == MTLO) begin
      check({tag, "_mt_busy"}, {busy, done}, 0);
      check({tag, "_mt_hilo"}, {hi, lo}, exp);
      {m_hi, m_lo} = exp;
      return;
    end
    lat      = (o == DIV || o == DIVU) ? ITER + 1 : LAT;
    n        = 1;
    all_busy = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      all_busy &= busy;
      tick();
      n++;
    end
    all_busy &= busy;
    check({tag, "_lat"}, n, lat);
    check({tag, "_busy"}, all_busy, 1);
    tick();
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hilo"}, {hi, lo}, exp);
    {m_hi, m_lo} = exp;
  endtask

  initial begin
    int          n, seen;
    logic        all_st;
    logic [63:0] exp;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; read_req = 1'b0; cancel = 1'b0;
    op = MULT; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_ctl", {busy, stall, done}, 0);
    rst_n = 1'b1;
    tick();

    run_op(MULT, 32'hFFFF_FFFF, 32'd2, "mult");
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
    check("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, "div");
    check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIVU, 32'd7, 32'd0, "divu0");
    check("divu0_const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);

    run_op(MTLO, 32'd5, 32'd0, "mtlo");
    run_op(MTHI, 32'd0, 32'd0, "mthi");
    run_op(MADD, 32'd3, 32'd4, "madd");
`ifdef MULDIV_ACCUMULATE_EN
    check("madd_const", {hi, lo}, 64'd17);
    run_op(MSUB, 32'd3, 32'd6, "msub");
    check("msub_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("madd_ill_const", {hi, lo}, 64'd5);
`endif

    // Stall with read_req from t+5 and a competing start held through the divide.
    exp = ref_result(DIVU, 32'd100, 32'd7, {m_hi, m_lo});
    start = 1'b1; op = DIVU; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    read_req = 1'b1; start = 1'b1; op = MTLO; rs_val = 32'hABCD;
    #1;
    n = 5;
    all_st = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      all_st &= stall;
      tick();
      n++;
    end
    check("stall_lat", n, ITER + 1);
    check("stall_hold", all_st, 1);
    check("stall_fix", stall, 1);
    tick();
    check("stall_idle", stall, 0);
    check("stall_res", {hi, lo}, exp);
    tick();
    check("second_start", {hi, lo}, {exp[63:32], 32'hABCD});
    start = 1'b0; read_req = 1'b0;
    m_hi = exp[63:32];
    m_lo = 32'hABCD;

    // Cancel mid-divide.
    start = 1'b1; op = DIV; rs_val = 32'd1000; rt_val = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    #1;
    check("cancel_done", done, 0);
    tick();
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_hilo", {hi, lo}, {m_hi, m_lo});
    seen = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check("cancel_nodone", seen, 0);

    // Cancel in the multiply completion cycle.
    start = 1'b1; op = MULT; rs_val = 32'd9; rt_val = 32'd9;
    tick();
    start = 1'b0;
    repeat (LAT - 1) tick();
    cancel = 1'b1;
    #1;
    check("cancel_last_done", done, 0);
    tick();
    cancel = 1'b0;
    check("cancel_last_busy", busy, 0);
    check("cancel_last_hilo", {hi, lo}, {m_hi, m_lo});

    // cancel together with start in IDLE.
    start = 1'b1; cancel = 1'b1; op = MTLO; rs_val = 32'h55;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("cancel_idle", {hi, lo}, {m_hi, m_lo});

    repeat (60) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'd1;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      run_op(muldiv_op_t'($urandom_range(0, 9)), a, b, "rand");
    end

    // Asynchronous reset in the middle of a multiply.
    start = 1'b1; op = MULT; rs_val = 32'h1234; rt_val = 32'h10;
    tick();
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 0);
    check("arst_ctl", {busy, stall, done}, 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(MULT, 32'h1234, 32'h10, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle HI/LO unit controller for the EX stage. It accepts multiply, divide, accumulate and move-to-HI/LO operations that the decoder tags via the control word, then sequences an iterative divider and a pipelined multiplier. It owns the architectural HI/LO registers and raises a pipeline stall while a result is pending and the pipeline needs HI/LO or the unit.

Parameters:
MUL_LATENCY, 3, cycles from accept to HI/LO update for multiply-class ops (range 1..8).
DIV_ITER, 32, radix-2 divider iterations (fixed 32; exposed for bench shortening only).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  EX-stage op valid; held by the pipeline until accepted
op  in  4  signals::muldiv_op_t: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO
rs_val  in  32  forwarded rs operand
rt_val  in  32  forwarded rt operand
read_req  in  1  MFHI/MFLO in EX this cycle
cancel  in  1  flush; aborts the in-flight op
busy  out  1  op in progress
stall  out  1  pipeline hold request
done  out  1  one-cycle pulse in the cycle HI/LO are written by a multi-cycle op
ill  out  1  op unsupported in this build (combinational, qualified by start)
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset: state IDLE; hi, lo, busy, stall, done = 0; counters and internal operand registers = 0. Reset mid-operation abandons the op.
- States: IDLE, MUL, DIV, FIX.
- Accept: start & ~busy & ~cancel in cycle t.
- IDLE->MUL on an accepted multiply-class op. Operands are registered at t. busy is high t+1..t+MUL_LATENCY. At the end of cycle t+MUL_LATENCY, {hi,lo} is written with the product (MULT/MULTU), {hi,lo}+product (MADD*), or {hi,lo}-product (MSUB*), mod 2^64. done pulses in t+MUL_LATENCY. Next state is IDLE.
- Products: signed variants sign-extend both operands to 64 bits; unsigned variants zero-extend.
- IDLE->DIV on an accepted DIV/DIVU. Operands are stored as magnitudes plus sign flags, and the counter is loaded with DIV_ITER. One restoring step per cycle. After the last step the state goes to FIX.
- FIX lasts one cycle. quotient is negated if the operand signs differ. remainder takes the sign of the dividend. lo=quotient and hi=remainder are written at the end of FIX. done pulses in FIX. Next state is IDLE.
- Divide timing: busy is high t+1..t+DIV_ITER+1, i.e. 33 cycles.
- Divide by zero is defined: the natural restoring result, quotient=0xFFFFFFFF, remainder=dividend. The signed case follows the same sign fixup.
- MTHI/MTLO: written at the end of the accept cycle, with no busy and no done.
- stall = busy & (start | read_req). The pipeline holds EX. A start while busy is not accepted.
- MFHI/MFLO in the completion cycle still stalls. hi/lo update at that clock edge, and the read proceeds on the next cycle.
- cancel while busy: return to IDLE next cycle. hi/lo are unchanged and done is suppressed. Cancel in the completion cycle also wins.
- cancel & start in IDLE: not accepted.
- ill = start & op is an accumulate op & macro absent. An ill op is never accepted, and stall is not raised for it.

Optional Feature:
- Macro: MULDIV_ACCUMULATE_EN.
- When defined: MADD, MADDU, MSUB and MSUBU behave as above.
- When undefined: the accumulate/subtract adder is removed. Those ops assert ill and leave state, hi and lo untouched, so the decoder raises a reserved-instruction exception.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_t enum (4-bit encoding);
  - state_t enum;
  - helper functions is_mul_op, is_div_op, is_signed_op, is_acc_op.
- The decoder imports muldiv_op_t into signals::control_t.
- Natural sub-module: div_step_unit, combinational. It performs one restoring shift-subtract step: inputs are partial remainder, quotient and divisor magnitude; outputs are the next remainder and quotient.
- The multiplier is a registered delay chain inside the top.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=2 -> done at t+3; hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
- MTLO 5, MTHI 0, then MADD rs=3, rt=4 -> lo=17, hi=0. MSUB rs=3, rt=6 -> lo=0xFFFFFFFF, hi=0xFFFFFFFF. With the macro undefined, MADD -> ill=1 and hi/lo unchanged.
- DIV issued, read_req asserted at t+5 -> stall high until the FIX cycle inclusive, low after. A second start during DIV is not accepted until IDLE.
- DIV issued, cancel at t+10 -> busy low at t+11, hi/lo hold their prior values, no done pulse.
- rst_n pulsed low mid-MUL (async, off clock edge) -> all outputs 0 immediately. A new MULT after release completes normally.
